// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// mips_cpu_pkg: shared CPU types and helpers for the multiply/divide unit.
// Rev 1.0
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  localparam int MD_WIDTH = 32;
  localparam logic [4:0] MD_LAST_ITER = 5'd31;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x,
                                                input logic is_signed);
    return (is_signed && x[MD_WIDTH-1]) ? (~x + 32'd1) : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// mult_div_unit_if: control-path request/result bundle for the multiply/divide unit.
// Rev 1.0
interface mult_div_unit_if;
  import mips_cpu_pkg::*;

  logic        start;
  md_op_t      op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );

endinterface
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// mult_div_unit: 33-cycle iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Rev 1.0
module mult_div_unit
  import mips_cpu_pkg::*;
(
  input  wire logic  clk,
  input  wire logic  reset_n,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_acc;
  logic [31:0] r_bmag;
  logic [31:0] r_a_orig;
  logic        r_is_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_b_zero;
  logic [4:0]  r_cnt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signed;
  logic [32:0] w_mul_sum;
  logic [32:0] w_div_trial;
  logic [63:0] w_acc_step;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == MD_LAST_ITER) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_signed = (bus.op == MD_MULT) || (bus.op == MD_DIV);

  // Multiply: upper half accumulates, lower half shifts the multiplier out LSB-first.
  // Divide: upper half is the partial remainder, lower half shifts dividend in / quotient out.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_bmag} : 33'd0);
    w_div_trial = r_acc[63:31] - {1'b0, r_bmag};
    if (r_is_div) begin
      w_acc_step = w_div_trial[32] ? {r_acc[62:0], 1'b0}
                                   : {w_div_trial[31:0], r_acc[30:0], 1'b1};
    end else begin
      w_acc_step = {w_mul_sum, r_acc[31:1]};
    end
  end

  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    if (!r_is_div) begin
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end else if (r_b_zero) begin
      w_fix_hi = r_a_orig;
      w_fix_lo = 32'hFFFF_FFFF;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_bmag   <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (bus.mthi) r_hi <= bus.wdata;
          if (bus.mtlo) r_lo <= bus.wdata;
          if (bus.start) begin
            r_acc    <= {32'd0, md_abs(bus.a, w_signed)};
            r_bmag   <= md_abs(bus.b, w_signed);
            r_a_orig <= bus.a;
            r_is_div <= bus.op[1];
            r_neg_q  <= w_signed & (bus.a[31] ^ bus.b[31]);
            r_neg_r  <= w_signed & bus.a[31];
            r_b_zero <= (bus.b == 32'd0);
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + 5'd1;
        end
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// tb_mult_div_unit: scoreboard bench comparing HI/LO at each done pulse against an arithmetic model.
// Rev 1.0
module tb_mult_div_unit;
  import mips_cpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] exp_q[$];
  int          busy_cycles = 0;
  logic        check_done_low = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected {HI, LO} straight from signed/unsigned 64-bit arithmetic.
  function automatic logic [63:0] model(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, sp, sq, sr;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      MD_MULT:  begin sp = sx * sy; return sp; end
      MD_MULTU: return ux * uy;
      MD_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        sq = sx / sy;
        sr = sx % sy;
        return {sr[31:0], sq[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset_n) begin
      busy_cycles    = 0;
      check_done_low = 1'b0;
    end else begin
      if (check_done_low) begin
        check("done_single_pulse", {63'd0, bus.done}, 64'd0);
        check_done_low = 1'b0;
      end
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {63'd0, bus.done}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("hi", {32'd0, bus.hi}, {32'd0, e[63:32]});
          check("lo", {32'd0, bus.lo}, {32'd0, e[31:0]});
          check("busy_cycles", 64'(busy_cycles), 64'd33);
          check("busy_low_at_done", {63'd0, bus.busy}, 64'd0);
        end
        busy_cycles    = 0;
        check_done_low = 1'b1;
      end
    end
  end

  task automatic issue(input md_op_t o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("issue_timeout", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    exp_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = md_op_t'($urandom_range(0, 3));
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.op    = MD_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hi", {32'd0, bus.hi}, 64'd0);
    check("rst_lo", {32'd0, bus.lo}, 64'd0);
    #2 reset_n = 1'b1;

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(MD_MULT,  32'hFFFF_FFFD, 32'd5);
    issue(MD_DIV,   32'hFFFF_FFF9, 32'd2);
    issue(MD_DIVU,  32'd7,         32'd2);
    issue(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    issue(MD_DIVU,  32'h0000_1234, 32'd0);
    issue(MD_DIV,   32'hFFFF_FF00, 32'd0);
    wait_idle();

    // Request and MTHI during an operation must both be dropped.
    issue(MD_MULT, 32'h1234_5678, 32'hFEDC_BA98);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MD_DIVU;
    bus.a     = 32'd99;
    bus.b     = 32'd3;
    bus.mthi  = 1'b1;
    bus.wdata = 32'h0000_00AA;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0000_0055;
    @(posedge clk);
    #1;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check("mthi", {32'd0, bus.hi}, 64'h55);
    check("mtlo", {32'd0, bus.lo}, 64'h55);

    issue(MD_MULT, 32'h0001_0003, 32'hFFFF_0007);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check("midrst_done", {63'd0, bus.done}, 64'd0);
    check("midrst_hi", {32'd0, bus.hi}, 64'd0);
    check("midrst_lo", {32'd0, bus.lo}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;

    issue(MD_DIVU, 32'd100, 32'd7);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      issue(md_op_t'($urandom_range(0, 3)), pick(), pick());
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU over 33 clock cycles and owns the architectural HI/LO registers. The single-cycle ALU cannot produce 64-bit products or quotient/remainder pairs, so this block is its multi-cycle counterpart. The control path issues a request with `start`, stalls on `busy`, and reads HI/LO for MFHI/MFLO.

## Interface
Parameters:
- None. Width is fixed at 32 bits.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request an operation. Sampled only in IDLE.
- `op` in 2: operation select, type `md_op_t`: MULT=00, MULTU=01, DIV=10, DIVU=11.
- `a` in 32: multiplicand or dividend (rs). Sampled with `start`.
- `b` in 32: multiplier or divisor (rt). Sampled with `start`.
- `mthi` in 1: write `wdata` to HI. Honoured only in IDLE.
- `mtlo` in 1: write `wdata` to LO. Honoured only in IDLE.
- `wdata` in 32: MTHI/MTLO data.
- `busy` out 1: an operation is in flight; the control path stalls the dependent instruction.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

Clock and reset are fixed: one clock; reset is asynchronous and active-low.

## Operation
- States:
  - IDLE.
  - RUN: 5-bit iteration counter.
  - FIX: sign correction and HI/LO write.
- IDLE with `start`=1:
  - Latch the operand magnitudes. Signed ops use the two's-complement absolute value; 0x80000000 maps to the unsigned magnitude 0x80000000.
  - Latch the result signs:
    - Product/quotient sign is sign(a) XOR sign(b).
    - Remainder sign is sign(a).
  - Latch the `b`==0 flag. Clear the counter. Go to RUN.
- RUN, multiply: one shift-add step per cycle over a 64-bit accumulator (LSB-first multiplier).
- RUN, divide: one restoring-division step per cycle (MSB-first), with a 33-bit partial remainder.
- RUN ends after exactly 32 iterations, then goes to FIX.
- FIX:
  - Negate the product, quotient and/or remainder as the latched signs require (signed ops only).
  - Write HI/LO:
    - Multiply: HI = product[63:32], LO = product[31:0].
    - Divide: LO = quotient, HI = remainder.
  - Go to IDLE and register `done`=1.
- Division by zero (signed or unsigned): LO=0xFFFFFFFF, HI = original `a`. No sign correction.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and needs no special case.
- `start` while not IDLE: ignored. The request is not queued.
- `mthi`/`mtlo` while not IDLE: ignored.
- `mthi` and `mtlo` together: both written.
- `mthi`/`mtlo` in the same cycle as an accepted `start`: the write takes effect. The operation result overwrites it in FIX.
- `op` and operands are don't-care except in the cycle `start` is accepted.
- `busy` = (state != IDLE), decoded directly from the state register.

## Timing
- Reset values: state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter 0.
- `reset_n` low mid-operation: immediate return to reset values. The partial result is discarded.
- `start` is accepted at edge E0. `busy`=1 from after E0 until after E33, i.e. 33 cycles.
- Edges E1–E32 perform RUN iterations. Edge E33 executes FIX.
- After E33:
  - `hi`/`lo` are updated.
  - `busy`=0.
  - `done`=1 for exactly one cycle.
- A new `start` is accepted in the `done` cycle (back-to-back ops). Throughput is one operation per 34 cycles.
- MTHI/MTLO: HI/LO update at the accepting edge and are visible the next cycle.

## Structure
- `md_op_t` enum goes in the shared CPU package `mips_cpu_pkg`. The state enum (IDLE/RUN/FIX) stays local.
- Single module, no sub-module. Multiply and divide share the 64-bit accumulator and the counter.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after E33: hi=0xFFFFFFFE, lo=0x00000001, `done` pulses once, `busy` high exactly 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234.
- Second `start` and `mthi` (wdata=0xAA) at cycle 10 of an operation → both ignored; the result matches a lone-op run. Then in IDLE, `mthi`+`mtlo` with wdata=0x55 → hi=lo=0x55 next cycle.
- `reset_n` pulsed low at cycle 15 of a MULT → `busy`, `done`, `hi`, `lo` = 0 immediately. A fresh DIVU 100/7 afterwards gives lo=14, hi=2.
